// File: rtl/sb3320_pkg.sv
// sb3320 shared definitions: turn command codes (also used by motor
// control), sequencer state encoding and line-sensor pattern names.
package sb3320_pkg;

    localparam logic [2:0] TURN_STOP    = 3'b000;
    localparam logic [2:0] TURN_FORWARD = 3'b001;
    localparam logic [2:0] TURN_LEFT    = 3'b010;
    localparam logic [2:0] TURN_RIGHT   = 3'b011;
    localparam logic [2:0] TURN_EXTREME = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_NODE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    // {left, center, right}, 1 = line under sensor
    localparam logic [2:0] LINE_NONE   = 3'b000;
    localparam logic [2:0] LINE_R      = 3'b001;
    localparam logic [2:0] LINE_C      = 3'b010;
    localparam logic [2:0] LINE_CR     = 3'b011;
    localparam logic [2:0] LINE_L      = 3'b100;
    localparam logic [2:0] LINE_SPLIT  = 3'b101;
    localparam logic [2:0] LINE_LC     = 3'b110;
    localparam logic [2:0] LINE_ALL    = 3'b111;

endpackage

// File: rtl/sb3320_line_filter.sv
// sb3320 line-sensor debounce: a pattern is accepted once it has been seen
// on STABLE_SAMPLES consecutive qualified samples.
// Ports: clk, rst_n (sync, active-low), sample_valid, line[2:0] in;
//        stable_line[2:0] out (registered, resets to 000).
module sb3320_line_filter
    import sb3320_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [2:0] line,
    output logic [2:0] stable_line
);

    localparam logic [3:0] NEED = 4'(STABLE_SAMPLES);

    logic [2:0] prev;
    logic [3:0] match_cnt;
    logic [3:0] cnt_n;

    // count of consecutive identical samples, including this one
    always_comb begin
        cnt_n = 4'd1;
        if (line == prev) begin
            cnt_n = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev        <= LINE_NONE;
            match_cnt   <= 4'd0;
            stable_line <= LINE_NONE;
        end else if (sample_valid) begin
            prev      <= line;
            match_cnt <= cnt_n;
            if (cnt_n == NEED) begin
                stable_line <= line;
            end
        end
    end

endmodule

// File: rtl/sb3320_turn_controller.sv
// sb3320 line-follow sequencer: debounced sensors drive a
// follow/node/search FSM that issues one registered turn code per clock.
// Ports: clk_50, rst_n (sync, active-low), start, halt, sample_valid,
//        line[2:0] in; turn[2:0], node_pulse, node_count[3:0], busy out.
// Build option: SB3320_NODE_LIMIT_EN ends the run in DONE after the
// hold of the node that brings node_count to MAX_NODES.
module sb3320_turn_controller
    import sb3320_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned NODE_HOLD      = 25_000_000,
    parameter int unsigned SEARCH_MIN     = 10_000_000,
    parameter int unsigned MAX_NODES      = 8
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    input  logic       sample_valid,
    input  logic [2:0] line,
    output logic [2:0] turn,
    output logic       node_pulse,
    output logic [3:0] node_count,
    output logic       busy
);

    localparam logic [3:0]  NODE_LIMIT = 4'(MAX_NODES);
    localparam logic [31:0] HOLD_LAST  = NODE_HOLD - 32'd1;
    localparam logic [31:0] SRCH_MIN   = SEARCH_MIN;

`ifdef SB3320_NODE_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    logic [2:0] stable_line;

    sb3320_line_filter #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_filter (
        .clk         (clk_50),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .line        (line),
        .stable_line (stable_line)
    );

    state_t      state, state_n;
    logic [2:0]  turn_n;
    logic        pulse_n;
    logic [3:0]  count_n;
    logic        busy_n;
    logic [31:0] dwell, dwell_n;
    logic        follow;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            turn       <= TURN_STOP;
            node_pulse <= 1'b0;
            node_count <= 4'd0;
            busy       <= 1'b0;
            dwell      <= 32'd0;
        end else begin
            state      <= state_n;
            turn       <= turn_n;
            node_pulse <= pulse_n;
            node_count <= count_n;
            busy       <= busy_n;
            dwell      <= dwell_n;
        end
    end

    always_comb begin
        state_n = state;
        turn_n  = turn;
        pulse_n = 1'b0;
        count_n = node_count;
        dwell_n = dwell;
        follow  = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                turn_n  = TURN_STOP;
                dwell_n = 32'd0;
                if (start) begin
                    state_n = ST_FOLLOW;
                    turn_n  = TURN_FORWARD;
                    count_n = 4'd0;
                end
            end
            ST_FOLLOW: begin
                follow = 1'b1;
            end
            ST_NODE: begin
                turn_n  = TURN_FORWARD;
                dwell_n = dwell + 32'd1;
                // last hold cycle: the decode at this edge replaces
                // the forward command so the hold is exactly NODE_HOLD
                if (dwell >= HOLD_LAST) begin
                    if (LIMIT_EN && node_count == NODE_LIMIT) begin
                        state_n = ST_DONE;
                        turn_n  = TURN_STOP;
                        dwell_n = 32'd0;
                    end else begin
                        follow = 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                turn_n = TURN_EXTREME;
                if (dwell < SRCH_MIN) begin
                    dwell_n = dwell + 32'd1;
                end
                if (dwell >= SRCH_MIN && stable_line[1]) begin
                    follow = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                turn_n  = TURN_STOP;
            end
        endcase

        if (follow) begin
            state_n = ST_FOLLOW;
            dwell_n = 32'd0;
            unique case (stable_line)
                LINE_C:          turn_n = TURN_FORWARD;
                LINE_LC, LINE_L: turn_n = TURN_LEFT;
                LINE_CR, LINE_R: turn_n = TURN_RIGHT;
                LINE_SPLIT:      turn_n = turn;
                LINE_ALL: begin
                    state_n = ST_NODE;
                    turn_n  = TURN_FORWARD;
                    pulse_n = 1'b1;
                    count_n = (node_count == 4'hF) ? 4'hF
                                                   : node_count + 4'd1;
                end
                default: begin
                    state_n = ST_SEARCH;
                    turn_n  = TURN_EXTREME;
                end
            endcase
        end

        if (halt) begin
            state_n = ST_IDLE;
            turn_n  = TURN_STOP;
            pulse_n = 1'b0;
            count_n = node_count;
            dwell_n = 32'd0;
        end

        busy_n = (state_n == ST_FOLLOW) || (state_n == ST_NODE) ||
                 (state_n == ST_SEARCH);
    end

endmodule

// File: tb/tb_sb3320_turn_controller.sv
// Directed bench for sb3320_turn_controller (NODE_HOLD=20, SEARCH_MIN=16,
// MAX_NODES=2); expects DONE only when SB3320_NODE_LIMIT_EN is defined.
module tb_sb3320_turn_controller;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       sample_valid;
    logic [2:0] line;
    logic [2:0] turn;
    logic       node_pulse;
    logic [3:0] node_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk_50 = ~clk_50;

    sb3320_turn_controller #(
        .STABLE_SAMPLES(4),
        .NODE_HOLD     (20),
        .SEARCH_MIN    (16),
        .MAX_NODES     (2)
    ) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .sample_valid(sample_valid),
        .line        (line),
        .turn        (turn),
        .node_pulse  (node_pulse),
        .node_count  (node_count),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic strobes(input logic [2:0] v, input int k);
        for (int i = 0; i < k; i++) begin
            line = v;
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cycles for which turn holds `code`, bounded
    task automatic count_turn(input logic [2:0] code, output int cnt);
        cnt = 0;
        while (turn === code && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        sample_valid = 1'b0;
        line = 3'b000;
        tick();
        tick();
        chk("rst_turn", turn, 3'b000);
        chk("rst_pulse", node_pulse, 0);
        chk("rst_count", node_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        strobes(3'b010, 4);
        tick();
        chk("idle_turn", turn, 3'b000);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_turn", turn, 3'b001);

        for (int i = 0; i < 3; i++) begin
            strobes(3'b110, 1);
            chk("short_110", turn, 3'b001);
        end
        strobes(3'b010, 1);
        chk("short_010", turn, 3'b001);
        tick();
        chk("short_after", turn, 3'b001);

        strobes(3'b110, 4);
        chk("left_lat1", turn, 3'b001);
        tick();
        chk("left_lat2", turn, 3'b010);
        strobes(3'b011, 4);
        tick();
        chk("right", turn, 3'b011);
        strobes(3'b101, 4);
        tick();
        tick();
        chk("split_hold", turn, 3'b011);

        strobes(3'b111, 4);
        chk("node_pre_pulse", node_pulse, 0);
        tick();
        chk("node_pulse", node_pulse, 1);
        chk("node_count1", node_count, 1);
        chk("node_turn", turn, 3'b001);
        line = 3'b110;
        sample_valid = 1'b1;
        count_turn(3'b001, n);
        sample_valid = 1'b0;
        chk("node_hold_len", n, 20);
        chk("node_resume", turn, 3'b010);
        chk("node_pulse_off", node_pulse, 0);

        strobes(3'b000, 4);
        tick();
        chk("search_turn", turn, 3'b100);
        chk("search_busy", busy, 1);
        line = 3'b010;
        sample_valid = 1'b1;
        count_turn(3'b100, n);
        sample_valid = 1'b0;
        chk("search_len", n, 17);
        chk("search_exit", turn, 3'b001);

        strobes(3'b111, 4);
        tick();
        chk("node2_count", node_count, 2);
        tick();
        tick();
        tick();
        halt = 1'b1;
        tick();
        chk("halt_turn", turn, 3'b000);
        chk("halt_busy", busy, 0);
        chk("halt_count", node_count, 2);
        start = 1'b1;
        tick();
        chk("halt_start_busy", busy, 0);
        chk("halt_start_cnt", node_count, 2);
        halt = 1'b0;
        start = 1'b0;
        strobes(3'b010, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_count", node_count, 0);
        chk("restart_busy", busy, 1);
        chk("restart_turn", turn, 3'b001);

        strobes(3'b111, 4);
        tick();
        chk("lim_n1_count", node_count, 1);
        line = 3'b010;
        sample_valid = 1'b1;
        repeat (20) tick();
        sample_valid = 1'b0;
        chk("lim_n1_busy", busy, 1);
        chk("lim_n1_turn", turn, 3'b001);
        strobes(3'b111, 4);
        tick();
        chk("lim_n2_count", node_count, 2);
        chk("lim_n2_pulse", node_pulse, 1);
        line = 3'b010;
        sample_valid = 1'b1;
        repeat (19) tick();
        chk("lim_last_hold", turn, 3'b001);
        tick();
        sample_valid = 1'b0;
`ifdef SB3320_NODE_LIMIT_EN
        chk("done_turn", turn, 3'b000);
        chk("done_busy", busy, 0);
        repeat (3) tick();
        chk("done_stay_turn", turn, 3'b000);
        chk("done_stay_busy", busy, 0);
`else
        chk("nolim_turn", turn, 3'b001);
        chk("nolim_busy", busy, 1);
        repeat (3) tick();
        chk("nolim_stay_turn", turn, 3'b001);
        chk("nolim_stay_busy", busy, 1);
`endif
        chk("lim_count_hold", node_count, 2);

        rst_n = 1'b0;
        tick();
        chk("mid_rst_turn", turn, 3'b000);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", node_count, 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_start", turn, 3'b001);
        tick();
        chk("filter_reset", turn, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
